// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Responder side of the load/store unit's data-memory interface. Models a
// byte-addressed, little-endian data memory with independent read and write
// channels, each accepting one request at a time and completing after a fixed
// latency with a one-cycle valid pulse. Supports word (LW/SW) and byte (LB/SB)
// accesses.
//
// Configuration macro:
//   DMEM_LB_SIGN_EXT_EN  defined   -> LB sign-extends the loaded byte
//                        undefined -> LB zero-extends the loaded byte
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   write_enable/address/value   write request; store_byte selects SB vs SW
//   write_ready                  write channel idle
//   write_valid/write_error      one-cycle completion pulse, error qualifier
//   read_enable/address          read request; load_byte selects LB vs LW
//   read_ready                   read channel idle
//   read_value                   load result, held until the next completion
//   read_valid/read_error        one-cycle completion pulse, error qualifier
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int MEM_SIZE_BYTES = 8192,
    parameter int WRITE_LATENCY  = 10,
    parameter int READ_LATENCY   = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        write_enable,
    input  logic [31:0] write_address,
    input  logic [31:0] write_value,
    input  logic        store_byte,
    output logic        write_ready,
    output logic        write_valid,
    output logic        write_error,
    input  logic        read_enable,
    input  logic [31:0] read_address,
    input  logic        load_byte,
    output logic        read_ready,
    output logic [31:0] read_value,
    output logic        read_valid,
    output logic        read_error
);

    localparam int AW  = $clog2(MEM_SIZE_BYTES);
    localparam int WCW = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
    localparam int RCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WCW-1:0] WCNT_INIT = WCW'(WRITE_LATENCY - 1);
    localparam logic [RCW-1:0] RCNT_INIT = RCW'(READ_LATENCY - 1);

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_e;

    // Misaligned word access, or any byte of the access past the end of memory.
    function automatic logic access_err(input logic [31:0] addr, input logic is_byte);
        logic [32:0] end_addr;
        end_addr = {1'b0, addr} + (is_byte ? 33'd1 : 33'd4);
        return (!is_byte && (addr[1:0] != 2'b00)) ||
               (end_addr > 33'(MEM_SIZE_BYTES));
    endfunction

    logic [7:0] mem [MEM_SIZE_BYTES];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    ch_state_e        wstate_q, wstate_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wbyte_q, wbyte_d;
    logic             wcommit;
    logic             wr_err;
    logic [AW-1:0]    widx;

    assign wr_err = access_err(waddr_q, wbyte_q);
    assign widx   = waddr_q[AW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wstate_q <= CH_IDLE;
            wcnt_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wbyte_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wcnt_q   <= wcnt_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wbyte_q  <= wbyte_d;
        end
    end

    always_comb begin
        wstate_d    = wstate_q;
        wcnt_d      = wcnt_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wbyte_d     = wbyte_q;
        write_ready = 1'b0;
        write_valid = 1'b0;
        write_error = 1'b0;
        wcommit     = 1'b0;
        case (wstate_q)
            CH_IDLE: begin
                write_ready = 1'b1;
                if (write_enable) begin
                    waddr_d  = write_address;
                    wdata_d  = write_value;
                    wbyte_d  = store_byte;
                    wcnt_d   = WCNT_INIT;
                    wstate_d = CH_BUSY;
                end
            end
            CH_BUSY: begin
                if (wcnt_q == '0) begin
                    // Completion cycle: the memory update lands on the
                    // closing edge, so a read completing now sees old data.
                    write_valid = 1'b1;
                    write_error = wr_err;
                    wcommit     = !wr_err;
                    wstate_d    = CH_IDLE;
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end
            default: wstate_d = CH_IDLE;
        endcase
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wcommit) begin
            mem[widx] <= wdata_q[7:0];
            if (!wbyte_q) begin
                mem[widx + AW'(1)] <= wdata_q[15:8];
                mem[widx + AW'(2)] <= wdata_q[23:16];
                mem[widx + AW'(3)] <= wdata_q[31:24];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    ch_state_e        rstate_q, rstate_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic [31:0]      raddr_q, raddr_d;
    logic             rbyte_q, rbyte_d;
    logic [31:0]      rvalue_q, rvalue_d;
    logic             rd_done;
    logic             rd_err;
    logic [AW-1:0]    ridx;
    logic [7:0]       lb_byte;
    logic [31:0]      lb_word;
    logic [31:0]      lw_word;
    logic [31:0]      rd_result;

    assign rd_err  = access_err(raddr_q, rbyte_q);
    assign ridx    = raddr_q[AW-1:0];
    assign lb_byte = mem[ridx];
    assign lw_word = {mem[ridx + AW'(3)], mem[ridx + AW'(2)],
                      mem[ridx + AW'(1)], mem[ridx]};

`ifdef DMEM_LB_SIGN_EXT_EN
    assign lb_word = {{24{lb_byte[7]}}, lb_byte};
`else
    assign lb_word = {24'd0, lb_byte};
`endif

    // Memory is sampled combinationally in the completion cycle, so writes
    // committed on any earlier edge are visible.
    assign rd_result  = rd_err ? 32'd0 : (rbyte_q ? lb_word : lw_word);
    assign read_value = rd_done ? rd_result : rvalue_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstate_q <= CH_IDLE;
            rcnt_q   <= '0;
            raddr_q  <= '0;
            rbyte_q  <= 1'b0;
            rvalue_q <= '0;
        end else begin
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            raddr_q  <= raddr_d;
            rbyte_q  <= rbyte_d;
            rvalue_q <= rvalue_d;
        end
    end

    always_comb begin
        rstate_d   = rstate_q;
        rcnt_d     = rcnt_q;
        raddr_d    = raddr_q;
        rbyte_d    = rbyte_q;
        rvalue_d   = rvalue_q;
        read_ready = 1'b0;
        read_valid = 1'b0;
        read_error = 1'b0;
        rd_done    = 1'b0;
        case (rstate_q)
            CH_IDLE: begin
                read_ready = 1'b1;
                if (read_enable) begin
                    raddr_d  = read_address;
                    rbyte_d  = load_byte;
                    rcnt_d   = RCNT_INIT;
                    rstate_d = CH_BUSY;
                end
            end
            CH_BUSY: begin
                if (rcnt_q == '0) begin
                    rd_done    = 1'b1;
                    read_valid = 1'b1;
                    read_error = rd_err;
                    rvalue_d   = rd_result;
                    rstate_d   = CH_IDLE;
                end else begin
                    rcnt_d = rcnt_q - RCW'(1);
                end
            end
            default: rstate_d = CH_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at default parameters
// (8192 bytes, write/read latency 10).
module tb_data_mem_responder;

    logic        clk;
    logic        reset_n;
    logic        write_enable;
    logic [31:0] write_address;
    logic [31:0] write_value;
    logic        store_byte;
    logic        write_ready;
    logic        write_valid;
    logic        write_error;
    logic        read_enable;
    logic [31:0] read_address;
    logic        load_byte;
    logic        read_ready;
    logic [31:0] read_value;
    logic        read_valid;
    logic        read_error;

    int errors = 0;
    int checks = 0;

    data_mem_responder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_value   (write_value),
        .store_byte    (store_byte),
        .write_ready   (write_ready),
        .write_valid   (write_valid),
        .write_error   (write_error),
        .read_enable   (read_enable),
        .read_address  (read_address),
        .load_byte     (load_byte),
        .read_ready    (read_ready),
        .read_value    (read_value),
        .read_valid    (read_valid),
        .read_error    (read_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lbx(input logic [7:0] b);
`ifdef DMEM_LB_SIGN_EXT_EN
        return {{24{b[7]}}, b};
`else
        return {24'd0, b};
`endif
    endfunction

    // All tasks enter and leave at posedge+1.
    task automatic wr_txn(input logic [31:0] a, input logic [31:0] v, input logic sb,
                          output int lat, output logic err);
        int n;
        n = 0;
        while (!write_ready && n < 100) begin @(posedge clk); #1; n++; end
        write_enable = 1'b1; write_address = a; write_value = v; store_byte = sb;
        @(posedge clk); #1;
        write_enable = 1'b0;
        lat = 1;
        while (!write_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        err = write_error;
    endtask

    task automatic rd_txn(input logic [31:0] a, input logic lb,
                          output int lat, output logic [31:0] val, output logic err);
        int n;
        n = 0;
        while (!read_ready && n < 100) begin @(posedge clk); #1; n++; end
        read_enable = 1'b1; read_address = a; load_byte = lb;
        @(posedge clk); #1;
        read_enable = 1'b0;
        lat = 1;
        while (!read_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        val = read_value;
        err = read_error;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        write_enable = 0; write_address = 0; write_value = 0; store_byte = 0;
        read_enable = 0; read_address = 0; load_byte = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (write_ready !== 1'b1) begin errors++; $display("FAIL reset_wready: got %b expected 1", write_ready); end
        checks++; if (read_ready !== 1'b1) begin errors++; $display("FAIL reset_rready: got %b expected 1", read_ready); end
        checks++; if (write_valid !== 1'b0 || write_error !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b/%b expected 0/0", write_valid, write_error); end
        checks++; if (read_valid !== 1'b0 || read_error !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b/%b expected 0/0", read_valid, read_error); end
        checks++; if (read_value !== 32'd0) begin errors++; $display("FAIL reset_rvalue: got %h expected 0", read_value); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (write_ready !== 1'b1 || read_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b/%b expected 1/1", write_ready, read_ready); end
    endtask

    task automatic test_sw_lw();
        int lat; logic err; logic [31:0] v;
        wr_txn(32'h10, 32'hDEADBEEF, 1'b0, lat, err);
        checks++; if (lat !== 10) begin errors++; $display("FAIL sw_latency: got %0d expected 10", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sw_error: got %b expected 0", err); end
        @(posedge clk); #1;
        checks++; if (write_ready !== 1'b1 || write_valid !== 1'b0) begin errors++; $display("FAIL sw_after: got ready=%b valid=%b expected 1/0", write_ready, write_valid); end
        rd_txn(32'h10, 1'b0, lat, v, err);
        checks++; if (lat !== 10) begin errors++; $display("FAIL lw_latency: got %0d expected 10", lat); end
        checks++; if (v !== 32'hDEADBEEF || err !== 1'b0) begin errors++; $display("FAIL lw_value: got %h err=%b expected deadbeef err=0", v, err); end
        @(posedge clk); #1;
        checks++; if (read_value !== 32'hDEADBEEF || read_valid !== 1'b0) begin errors++; $display("FAIL lw_hold: got %h valid=%b expected deadbeef valid=0", read_value, read_valid); end
    endtask

    task automatic test_lb();
        int lat; logic err; logic [31:0] v;
        rd_txn(32'h10, 1'b1, lat, v, err);
        checks++; if (v !== lbx(8'hEF) || err !== 1'b0) begin errors++; $display("FAIL lb_10: got %h expected %h", v, lbx(8'hEF)); end
        rd_txn(32'h11, 1'b1, lat, v, err);
        checks++; if (v !== lbx(8'hBE)) begin errors++; $display("FAIL lb_11: got %h expected %h", v, lbx(8'hBE)); end
        rd_txn(32'h13, 1'b1, lat, v, err);
        checks++; if (v !== lbx(8'hDE) || lat !== 10) begin errors++; $display("FAIL lb_13: got %h lat=%0d expected %h lat=10", v, lat, lbx(8'hDE)); end
    endtask

    task automatic test_sb();
        int lat; logic err; logic [31:0] v;
        wr_txn(32'h12, 32'hFFFFFF55, 1'b1, lat, err);
        checks++; if (lat !== 10 || err !== 1'b0) begin errors++; $display("FAIL sb_done: got lat=%0d err=%b expected 10/0", lat, err); end
        rd_txn(32'h10, 1'b0, lat, v, err);
        checks++; if (v !== 32'hDE55BEEF) begin errors++; $display("FAIL sb_lw: got %h expected de55beef", v); end
    endtask

    task automatic test_errors();
        int lat; logic err; logic [31:0] v;
        wr_txn(32'h1FFC, 32'h11223344, 1'b0, lat, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sw_top_ok: got err=%b expected 0", err); end
        rd_txn(32'h11, 1'b0, lat, v, err);
        checks++; if (err !== 1'b1 || v !== 32'd0 || lat !== 10) begin errors++; $display("FAIL lw_misaligned: got err=%b val=%h lat=%0d expected 1/0/10", err, v, lat); end
        @(posedge clk); #1;
        checks++; if (read_value !== 32'd0) begin errors++; $display("FAIL err_hold: got %h expected 0", read_value); end
        wr_txn(32'h1FFE, 32'hAABBCCDD, 1'b0, lat, err);
        checks++; if (err !== 1'b1 || lat !== 10) begin errors++; $display("FAIL sw_misaligned_oor: got err=%b lat=%0d expected 1/10", err, lat); end
        wr_txn(32'h2000, 32'h000000AB, 1'b1, lat, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sb_oor: got err=%b expected 1", err); end
        rd_txn(32'h1FFC, 1'b0, lat, v, err);
        checks++; if (v !== 32'h11223344 || err !== 1'b0) begin errors++; $display("FAIL lw_top_unchanged: got %h err=%b expected 11223344/0", v, err); end
        rd_txn(32'h1FFF, 1'b1, lat, v, err);
        checks++; if (v !== lbx(8'h11) || err !== 1'b0) begin errors++; $display("FAIL lb_last_byte: got %h err=%b expected %h/0", v, err, lbx(8'h11)); end
        rd_txn(32'h2000, 1'b1, lat, v, err);
        checks++; if (v !== 32'd0 || err !== 1'b1) begin errors++; $display("FAIL lb_oor: got %h err=%b expected 0/1", v, err); end
    endtask

    task automatic test_busy_ignore();
        int lat; logic err; logic [31:0] v;
        int pulses; int vcyc; logic busy_ready;
        wr_txn(32'h34, 32'h0C0C0C0C, 1'b0, lat, err);
        @(posedge clk); #1;
        write_enable = 1'b1; write_address = 32'h30; write_value = 32'hA5A5A5A5; store_byte = 1'b0;
        @(posedge clk); #1;
        write_enable = 1'b0;
        pulses = 0; vcyc = 0; busy_ready = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                busy_ready = write_ready;
                write_enable = 1'b1; write_address = 32'h34; write_value = 32'hBBBBBBBB;
            end
            if (c == 6) write_enable = 1'b0;
            if (write_valid) begin pulses++; vcyc = c; end
            @(posedge clk); #1;
        end
        checks++; if (busy_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", busy_ready); end
        checks++; if (pulses !== 1 || vcyc !== 10) begin errors++; $display("FAIL busy_one_pulse: got %0d pulses at %0d expected 1 at 10", pulses, vcyc); end
        rd_txn(32'h30, 1'b0, lat, v, err);
        checks++; if (v !== 32'hA5A5A5A5) begin errors++; $display("FAIL busy_first_data: got %h expected a5a5a5a5", v); end
        rd_txn(32'h34, 1'b0, lat, v, err);
        checks++; if (v !== 32'h0C0C0C0C) begin errors++; $display("FAIL busy_ignored_data: got %h expected 0c0c0c0c", v); end
    endtask

    task automatic test_overlap();
        int wlat, rlat; logic werr, rerr; logic [31:0] v;
        wr_txn(32'h40, 32'h01234567, 1'b0, wlat, werr);
        fork
            wr_txn(32'h40, 32'h89ABCDEF, 1'b0, wlat, werr);
            rd_txn(32'h40, 1'b0, rlat, v, rerr);
        join
        checks++; if (v !== 32'h01234567 || rlat !== 10) begin errors++; $display("FAIL same_cycle_old: got %h lat=%0d expected 01234567 lat=10", v, rlat); end
        rd_txn(32'h40, 1'b0, rlat, v, rerr);
        checks++; if (v !== 32'h89ABCDEF) begin errors++; $display("FAIL overlap_new: got %h expected 89abcdef", v); end
        fork
            wr_txn(32'h44, 32'h5A5A1234, 1'b0, wlat, werr);
            begin
                @(posedge clk); #1;
                rd_txn(32'h44, 1'b0, rlat, v, rerr);
            end
        join
        checks++; if (v !== 32'h5A5A1234 || rlat !== 10 || wlat !== 10) begin errors++; $display("FAIL earlier_commit_visible: got %h rlat=%0d wlat=%0d expected 5a5a1234/10/10", v, rlat, wlat); end
    endtask

    task automatic test_reset_inflight();
        int lat; logic err; logic [31:0] v; int pulses;
        wr_txn(32'h20, 32'hCAFEF00D, 1'b0, lat, err);
        @(posedge clk); #1;
        write_enable = 1'b1; write_address = 32'h20; write_value = 32'h0BADBEEF; store_byte = 1'b0;
        @(posedge clk); #1;
        write_enable = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (write_ready !== 1'b1 || write_valid !== 1'b0) begin errors++; $display("FAIL reset_inflight: got ready=%b valid=%b expected 1/0", write_ready, write_valid); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (write_valid) pulses++;
            @(posedge clk); #1;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_no_pulse: got %0d expected 0", pulses); end
        rd_txn(32'h20, 1'b0, lat, v, err);
        checks++; if (v !== 32'hCAFEF00D) begin errors++; $display("FAIL reset_no_commit: got %h expected cafef00d", v); end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_lb();
        test_sb();
        test_errors();
        test_busy_ignore();
        test_overlap();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
